module3_fine_sync_mul_arbiter: RTL and testbench



---
 rtl/module3_fine_sync_mul_arbiter_pkg.sv | 23 ++
 rtl/module3_fine_sync_mul_arbiter_if.sv | 31 +++
 rtl/module3_fine_sync_mul_arbiter_pipe.sv | 74 +++++++
 rtl/module3_fine_sync_mul_arbiter.sv | 107 ++++++++++
 tb/tb_module3_fine_sync_mul_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/module3_fine_sync_mul_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module3_fine_sync_pkg : shared widths and pipeline types for the multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
package module3_fine_sync_pkg;

   localparam int DIN_WIDTH  = 36;
   localparam int DOUT_WIDTH = 72;
   // Wide enough for the largest supported requester count (8)
   localparam int MUL_TAG_W  = 3;

   typedef logic [MUL_TAG_W-1:0] mul_tag_t;

   typedef struct packed {
      logic                  v;
      mul_tag_t              tag;
      logic [DOUT_WIDTH-1:0] data;
   } mul_pipe_t;

endpackage

`default_nettype wire

// File: rtl/module3_fine_sync_mul_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module3_fine_sync_mul_arbiter_if : requester/result bus of the shared multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
interface module3_fine_sync_mul_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DIN_WIDTH  = 36,
   parameter int DOUT_WIDTH = 72
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*DIN_WIDTH-1:0] req_a;
   logic [NUM_REQ*DIN_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]           rsp_valid;
   logic [DOUT_WIDTH-1:0]        rsp_data;
   logic                         rsp_ready;
   logic                         pipe_empty;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, pipe_empty
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_data, pipe_empty
   );
endinterface

`default_nettype wire

// File: rtl/module3_fine_sync_mul_arbiter_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module3_fine_sync_mul_pipe : operand register + MUL_STAGES product registers
// Rev 1.0
// ---------------------------------------------------------------------------
module module3_fine_sync_mul_pipe
   import module3_fine_sync_pkg::*;
#(
   parameter int MUL_STAGES = 2
) (
   input  wire logic                        ap_clk,
   input  wire logic                        ap_rst_n,
   input  wire logic                        en,
   input  wire logic                        in_v,
   input  wire mul_tag_t                    in_tag,
   input  wire logic signed [DIN_WIDTH-1:0] in_a,
   input  wire logic signed [DIN_WIDTH-1:0] in_b,
   output mul_pipe_t                        out,
   output logic                             busy
);

   logic                          r_v0;
   mul_tag_t                      r_tag0;
   logic signed [DIN_WIDTH-1:0]   r_a0;
   logic signed [DIN_WIDTH-1:0]   r_b0;
   logic signed [DOUT_WIDTH-1:0]  w_a_ext;
   logic signed [DOUT_WIDTH-1:0]  w_b_ext;
   logic signed [DOUT_WIDTH-1:0]  w_prod;
   mul_pipe_t                     r_stage [1:MUL_STAGES];
   logic [MUL_STAGES:0]           w_v_all;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_v0   <= 1'b0;
         r_tag0 <= '0;
         r_a0   <= '0;
         r_b0   <= '0;
      end else if (en) begin
         r_v0   <= in_v;
         r_tag0 <= in_tag;
         r_a0   <= in_a;
         r_b0   <= in_b;
      end
   end

   // Full-width product: sign-extended operands make the wrap-free 72-bit result exact
   assign w_a_ext = {{(DOUT_WIDTH-DIN_WIDTH){r_a0[DIN_WIDTH-1]}}, r_a0};
   assign w_b_ext = {{(DOUT_WIDTH-DIN_WIDTH){r_b0[DIN_WIDTH-1]}}, r_b0};
   assign w_prod  = w_a_ext * w_b_ext;

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         for (int s = 1; s <= MUL_STAGES; s++) begin
            r_stage[s] <= '0;
         end
      end else if (en) begin
         r_stage[1] <= '{v: r_v0, tag: r_tag0, data: w_prod};
         for (int s = 2; s <= MUL_STAGES; s++) begin
            r_stage[s] <= r_stage[s-1];
         end
      end
   end

   assign w_v_all[0] = r_v0;
   for (genvar s = 1; s <= MUL_STAGES; s++) begin : g_vtap
      assign w_v_all[s] = r_stage[s].v;
   end

   assign out  = r_stage[MUL_STAGES];
   assign busy = |w_v_all;

endmodule

`default_nettype wire

// File: rtl/module3_fine_sync_mul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// module3_fine_sync_mul_arbiter : round-robin sharing of one 36x36 multiplier
// Rev 1.0
// ---------------------------------------------------------------------------
module module3_fine_sync_mul_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DIN_WIDTH  = 36,
   parameter int DOUT_WIDTH = 72,
   parameter int MUL_STAGES = 2,
   parameter int TAG_W      = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input wire logic                       ap_clk,
   input wire logic                       ap_rst_n,
   module3_fine_sync_mul_arbiter_if.slave bus
);
   import module3_fine_sync_pkg::*;

   logic [TAG_W-1:0]             r_ptr;
   logic [TAG_W-1:0]             w_idx;
   logic [TAG_W-1:0]             w_win;
   logic                         w_any;
   logic                         w_stall;
   logic                         w_accept;
   logic                         w_en;
   logic [NUM_REQ-1:0]           w_grant;
   logic [NUM_REQ-1:0]           w_rsp_valid;
   logic [DOUT_WIDTH-1:0]        w_rsp_data;
   logic signed [DIN_WIDTH-1:0]  w_a;
   logic signed [DIN_WIDTH-1:0]  w_b;
   mul_tag_t                     w_tag;
   mul_pipe_t                    w_last;
   logic                         w_busy;

   function automatic int wrap_idx(input int base, input int ofs);
      return (base + ofs >= NUM_REQ) ? base + ofs - NUM_REQ : base + ofs;
   endfunction

   // Scan ptr, ptr+1, ... and take the first requester holding valid
   always_comb begin
      w_any = 1'b0;
      w_win = '0;
      w_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = TAG_W'(wrap_idx(int'(r_ptr), k));
         if (!w_any && bus.req_valid[w_idx]) begin
            w_any = 1'b1;
            w_win = w_idx;
         end
      end
   end

   assign w_stall  = (|w_rsp_valid) & ~bus.rsp_ready;
   assign w_en     = ~w_stall;
   assign w_accept = ap_rst_n & w_any & ~w_stall;

   always_comb begin
      w_grant = '0;
      if (w_accept) begin
         w_grant[w_win] = 1'b1;
      end
   end

   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= (w_win == TAG_W'(NUM_REQ - 1)) ? '0 : w_win + TAG_W'(1);
      end
   end

   assign w_a   = bus.req_a[int'(w_win)*DIN_WIDTH +: DIN_WIDTH];
   assign w_b   = bus.req_b[int'(w_win)*DIN_WIDTH +: DIN_WIDTH];
   assign w_tag = mul_tag_t'(w_win);

   module3_fine_sync_mul_pipe #(
      .MUL_STAGES (MUL_STAGES)
   ) u_pipe (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .en       (w_en),
      .in_v     (w_accept),
      .in_tag   (w_tag),
      .in_a     (w_a),
      .in_b     (w_b),
      .out      (w_last),
      .busy     (w_busy)
   );

   always_comb begin
      w_rsp_valid = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_last.v && (w_last.tag == mul_tag_t'(i))) begin
            w_rsp_valid[i] = 1'b1;
         end
      end
   end

   assign w_rsp_data     = w_last.data;
   assign bus.req_ready  = w_grant;
   assign bus.rsp_valid  = w_rsp_valid;
   assign bus.rsp_data   = w_rsp_data;
   assign bus.pipe_empty = ~w_busy;

endmodule

`default_nettype wire

// File: tb/tb_module3_fine_sync_mul_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_module3_fine_sync_mul_arbiter : randomized bench with queue-based reference
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_module3_fine_sync_mul_arbiter;

   localparam int N  = 4;
   localparam int DW = 36;
   localparam int OW = 72;
   localparam int MS = 2;
   localparam logic signed [DW-1:0] MINV = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [DW-1:0] MAXV = {1'b0, {(DW-1){1'b1}}};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   module3_fine_sync_mul_arbiter_if #(.NUM_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW)) bus ();

   module3_fine_sync_mul_arbiter #(
      .NUM_REQ(N), .DIN_WIDTH(DW), .DOUT_WIDTH(OW), .MUL_STAGES(MS), .TAG_W(2)
   ) dut (
      .ap_clk   (clk),
      .ap_rst_n (rst_n),
      .bus      (bus)
   );

   typedef struct {
      int                     tag;
      logic signed [OW-1:0]   prod;
      longint                 due;
   } op_t;

   int                   n_checks = 0;
   int                   n_errors = 0;
   bit                   pend [N];
   logic signed [DW-1:0] op_a [N];
   logic signed [DW-1:0] op_b [N];
   bit                   rdy = 1'b1;
   bit                   rst_req = 1'b0;
   op_t                  q [$];
   int                   mptr = 0;
   longint               adv = 0;
   int                   cyc = 0;
   bit                   post_reset = 1'b1;
   logic [N-1:0]         obs_rdy;
   int                   dut_fire = 0;

   task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic signed [OW-1:0] mul_ref(input logic signed [DW-1:0] a,
                                                    input logic signed [DW-1:0] b);
      logic signed [OW-1:0] ea, eb;
      ea = a;
      eb = b;
      return ea * eb;
   endfunction

   function automatic int rr_pick();
      for (int k = 0; k < N; k++) begin
         if (pend[(mptr + k) % N]) return (mptr + k) % N;
      end
      return -1;
   endfunction

   function automatic bit pending_any();
      for (int i = 0; i < N; i++) if (pend[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic signed [DW-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0:       return MINV;
         1:       return MAXV;
         2:       return '0;
         default: return r[DW-1:0];
      endcase
   endfunction

   task automatic set_req(input int i, input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
      pend[i] = 1'b1;
      op_a[i] = a;
      op_b[i] = b;
   endtask

   // One clock: drive at negedge, compare against the reference, advance the reference at posedge
   task automatic cycle();
      bit           head_vis, stall;
      int           pick;
      logic [N-1:0] exp_rdy, exp_rv;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]          = pend[i];
         bus.req_a[i*DW +: DW]     = op_a[i];
         bus.req_b[i*DW +: DW]     = op_b[i];
      end
      bus.rsp_ready = rdy;
      rst_n         = rst_req;
      #1;
      head_vis = (q.size() > 0) && (adv >= q[0].due);
      stall    = head_vis && !rdy;
      pick     = rr_pick();
      exp_rdy  = '0;
      if (rst_req && !stall && pick >= 0) exp_rdy[pick] = 1'b1;
      exp_rv = '0;
      if (head_vis) exp_rv[q[0].tag] = 1'b1;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      chk("pipe_empty", bus.pipe_empty, q.size() == 0);
      if (head_vis) chk("rsp_data", bus.rsp_data, q[0].prod);
      if (post_reset) begin
         chk("rsp_data_reset", bus.rsp_data, '0);
         post_reset = 1'b0;
      end
      obs_rdy = bus.req_ready;
      if ((|bus.rsp_valid) && rdy) dut_fire++;
      @(posedge clk);
      cyc++;
      if (!rst_req) begin
         q.delete();
         mptr       = 0;
         post_reset = 1'b1;
      end else if (!stall) begin
         if (head_vis) void'(q.pop_front());
         if (pick >= 0) begin
            q.push_back('{tag: pick, prod: mul_ref(op_a[pick], op_b[pick]), due: adv + 1 + MS});
            pend[pick] = 1'b0;
            mptr       = (pick + 1) % N;
         end
         adv++;
      end
   endtask

   task automatic flush();
      int n = 0;
      rdy     = 1'b1;
      rst_req = 1'b1;
      while ((pending_any() || q.size() != 0) && n < 60) begin
         cycle();
         n++;
      end
      if (n >= 60) chk("flush_timeout", q.size(), 0);
   endtask

   initial begin
      int k, r2_assert, cnt0;
      bit r2_active;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;

      // Reset with every requester asking: nothing may be granted
      for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op());
      rst_req = 1'b0;
      repeat (2) cycle();
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      rst_req = 1'b1;
      cycle();

      // Single request, 3 * -5
      set_req(1, 36'sd3, -36'sd5);
      repeat (6) cycle();

      // All four held valid: 0,1,2,3,0,...
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, rnd_op(), rnd_op());
         cycle();
      end
      flush();

      // Operand extremes
      set_req(0, MINV, MINV);
      set_req(1, MAXV, MINV);
      set_req(2, '0, rnd_op());
      set_req(3, MAXV, MAXV);
      flush();

      // Backpressure: six operations, rsp_ready low for three cycles mid-stream
      dut_fire = 0;
      k = 0;
      for (int c = 0; c < 60 && (k < 6 || pending_any() || q.size() != 0); c++) begin
         if (k < 6 && !pend[k % N]) begin
            set_req(k % N, rnd_op(), rnd_op());
            k++;
         end
         rdy = !(c >= 4 && c < 7);
         cycle();
      end
      rdy = 1'b1;
      chk("bp_result_count", dut_fire, 6);

      // Reset with three operations in flight; afterwards requester 0 must win first
      set_req(0, rnd_op(), rnd_op());
      set_req(1, rnd_op(), rnd_op());
      set_req(2, rnd_op(), rnd_op());
      repeat (3) cycle();
      for (int i = 0; i < N; i++) if (!pend[i]) set_req(i, rnd_op(), rnd_op());
      rst_req = 1'b0;
      cycle();
      rst_req = 1'b1;
      cycle();
      chk("grant_after_reset", obs_rdy, 4'b0001);
      flush();
      repeat (4) cycle();

      // Bursty fairness: 0 always valid, 2 every third cycle
      cnt0      = 0;
      r2_active = 1'b0;
      r2_assert = 0;
      for (int c = 0; c < 36; c++) begin
         if (!pend[0]) set_req(0, rnd_op(), rnd_op());
         if (c % 3 == 0 && !pend[2]) begin
            set_req(2, rnd_op(), rnd_op());
            r2_assert = cyc;
            r2_active = 1'b1;
         end
         cycle();
         if (obs_rdy[0]) cnt0++;
         if (r2_active) begin
            if (obs_rdy[2]) begin
               chk("req2_within_2", (cyc - 1 - r2_assert) <= 2, 1'b1);
               r2_active = 1'b0;
            end else if (cyc - 1 - r2_assert >= 2) begin
               chk("req2_within_2", obs_rdy[2], 1'b1);
               r2_active = 1'b0;
            end
         end
      end
      chk("req0_share", cnt0 >= 18, 1'b1);
      flush();

      // Randomized traffic with random backpressure and occasional reset
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_op(), rnd_op());
         end
         rdy     = ($urandom_range(0, 3) != 0);
         rst_req = ($urandom_range(0, 99) != 0);
         cycle();
      end
      flush();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
